// File: rtl/bcd_pkg.sv
// Shared BCD constants and FSM state encoding for the BCD<->binary converter blocks.
package bcd_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;
    localparam int BIN_W      = 10;
    localparam int NUM_ITER   = 10;

    // Digit field above the binary accumulator in the working shift register.
    localparam int SR_W  = DIGIT_W * NUM_DIGITS + BIN_W;
    localparam int CNT_W = $clog2(NUM_ITER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADJ   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Reverse double-dabble digit corrector: a nibble that reached 8 or more after a
// right shift had a half-ten shifted in and is pulled back by 3.
module bcd_nibble_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_nib,
    output logic [DIGIT_W-1:0] o_nib
);

    assign o_nib = (i_nib >= DIGIT_W'(8)) ? i_nib - DIGIT_W'(3) : i_nib;

endmodule

// File: rtl/bcd2bin.sv
// Sequential 3-digit BCD to 10-bit binary converter (reverse double dabble), fixed
// 22-cycle start-to-done latency. Define BCD2BIN_DIGIT_CHECK_EN to flag non-decimal digits.
module bcd2bin
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIGIT_W-1:0] hunds,
    input  logic [DIGIT_W-1:0] tens,
    input  logic [DIGIT_W-1:0] units,
    output logic [BIN_W-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             r_state, w_state_nxt;
    logic [SR_W-1:0]    r_sr, w_sr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [BIN_W-1:0]   r_bin, w_bin_nxt;
    logic               r_done, w_done_nxt;
    logic [DIGIT_W-1:0] w_adj [NUM_DIGITS];

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic r_flag_q, w_flag_nxt;
    logic r_err, w_err_nxt;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .i_nib (r_sr[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .o_nib (w_adj[g])
        );
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_bin_nxt   = r_bin;
        w_done_nxt  = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        w_flag_nxt  = r_flag_q;
        w_err_nxt   = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sr_nxt    = {hunds, tens, units, {BIN_W{1'b0}}};
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    w_flag_nxt  = (hunds > DIGIT_W'(9)) | (tens > DIGIT_W'(9)) | (units > DIGIT_W'(9));
`endif
                end
            end
            SHIFT: begin
                w_sr_nxt    = r_sr >> 1;
                w_state_nxt = ADJ;
            end
            ADJ: begin
                w_sr_nxt = {w_adj[2], w_adj[1], w_adj[0], r_sr[BIN_W-1:0]};
                if (r_cnt == CNT_W'(NUM_ITER - 1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
                w_bin_nxt = r_flag_q ? '0 : r_sr[BIN_W-1:0];
                w_err_nxt = r_flag_q;
`else
                w_bin_nxt = r_sr[BIN_W-1:0];
`endif
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_done  <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            r_flag_q <= 1'b0;
            r_err    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bin   <= w_bin_nxt;
            r_done  <= w_done_nxt;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            r_flag_q <= w_flag_nxt;
            r_err    <= w_err_nxt;
`endif
        end
    end

    assign bin  = r_bin;
    assign done = r_done;
    assign busy = (r_state != IDLE);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign err  = r_err;
`else
    assign err  = 1'b0;
`endif

endmodule
